// File: rtl/pipe_pkg.sv
// Shared types for the five-stage pipeline controller:
// FSM states, forwarding-select codes and the per-stage shadow tag.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Wide enough for any register-file address this core will use.
  localparam int TAG_DST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_DST_W-1:0] dst;
    logic                 reg_write;
    logic                 mem_read;
  } tag_t;

  function automatic logic tag_hit(
    input tag_t                 t,
    input logic [TAG_DST_W-1:0] a
  );
    return t.valid & t.reg_write & (t.dst == a);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and operand forwarding selects for
// every source operand of the instruction sitting in ID.
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int FWD_EN     = 1
) (
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  input  tag_t                          ex_tag,
  input  tag_t                          mem_tag,
  input  tag_t                          wb_tag,
  output logic                          lu,
  output logic [2*NUM_SRC-1:0]          fwd_sel
);

  logic [TAG_DST_W-1:0] src;
  logic                 hit_ex;
  logic                 hit_mem;
  logic                 hit_wb;
  logic                 unused_tags;

  assign unused_tags = ^{mem_tag.mem_read, wb_tag.mem_read};

  always_comb begin
    lu      = 1'b0;
    fwd_sel = {NUM_SRC{FWD_RF}};
    src     = '0;
    hit_ex  = 1'b0;
    hit_mem = 1'b0;
    hit_wb  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src     = TAG_DST_W'(src_addr[i*REG_ADDR_W +: REG_ADDR_W]);
      hit_ex  = id_valid & src_used[i] & tag_hit(ex_tag, src);
      hit_mem = id_valid & src_used[i] & tag_hit(mem_tag, src);
      hit_wb  = id_valid & src_used[i] & tag_hit(wb_tag, src);
      if (hit_ex && ex_tag.mem_read) lu = 1'b1;
      // Without forwarding every in-flight producer blocks ID.
      if (FWD_EN == 0) begin
        if (hit_ex || hit_mem || hit_wb) lu = 1'b1;
      end else if (hit_ex && !ex_tag.mem_read) begin
        fwd_sel[2*i +: 2] = FWD_EXMEM;
      end else if (hit_mem) begin
        fwd_sel[2*i +: 2] = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage valid bits, shadow tags, register
// enables, flush/bubble, stalls, forwarding and retire counting.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int NUM_SRC    = 2,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          halt,
  input  logic                          fetch_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dst_addr,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic                          branch_taken,
  input  logic                          ext_stall,
  output logic                          pc_en,
  output logic                          ifid_en,
  output logic                          idex_en,
  output logic                          exmem_en,
  output logic                          memwb_en,
  output logic                          ifid_flush,
  output logic                          idex_bubble,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic [3:0]                    stage_valid,
  output logic                          wb_reg_write,
  output logic [REG_ADDR_W-1:0]         wb_dst_addr,
  output logic                          busy,
  output logic [CNT_W-1:0]              retire_count
);

  state_e           state_q;
  state_e           state_d;
  logic             id_valid_q;
  logic             id_valid_d;
  tag_t             ex_q;
  tag_t             ex_d;
  tag_t             mem_q;
  tag_t             mem_d;
  tag_t             wb_q;
  tag_t             wb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             active;
  logic             adv;
  logic             fetching;
  logic             lu;
  logic             ex_take;

  assign active   = (state_q != ST_IDLE);
  assign adv      = active & ~ext_stall;
  assign fetching = (state_q == ST_RUN) & fetch_valid & ~halt;
  assign ex_take  = id_valid_q & ~lu & ~branch_taken;

  assign stage_valid  = {wb_q.valid, mem_q.valid,
                         ex_q.valid, id_valid_q};
  assign wb_reg_write = wb_q.valid & wb_q.reg_write;
  assign wb_dst_addr  = wb_q.dst[REG_ADDR_W-1:0];
  assign busy         = active;
  assign retire_count = cnt_q;

  hazard_fwd_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_SRC    (NUM_SRC),
    .FWD_EN     (FWD_EN)
  ) u_hfu (
    .id_valid (id_valid_q),
    .src_addr (id_src_addr),
    .src_used (id_src_used),
    .ex_tag   (ex_q),
    .mem_tag  (mem_q),
    .wb_tag   (wb_q),
    .lu       (lu),
    .fwd_sel  (fwd_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ext_stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !halt) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (halt) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (stage_valid == 4'b0000) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = adv;
    memwb_en    = adv;
    if (adv) begin
      if (branch_taken) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu) begin
        idex_en     = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
      end
    end
  end

  always_comb begin
    id_valid_d = id_valid_q;
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;
    cnt_d      = cnt_q + CNT_W'(wb_q.valid & ~ext_stall);
    if (adv) begin
      wb_d           = mem_q;
      mem_d          = ex_q;
      ex_d.valid     = ex_take;
      ex_d.dst       = TAG_DST_W'(id_dst_addr);
      ex_d.reg_write = id_reg_write & ex_take;
      ex_d.mem_read  = id_mem_read & ex_take;
      // A stalled ID keeps its instruction; a branch kills it.
      if (branch_taken) begin
        id_valid_d = 1'b0;
      end else if (!lu) begin
        id_valid_d = fetching;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      cnt_q      <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: one forwarding and one stall-only instance
// driven alike, checked against a slot-array model and fixed cases.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       fetch_valid = 1'b0;
  logic [5:0] id_src_addr = '0;
  logic [1:0] id_src_used = '0;
  logic [2:0] id_dst_addr = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       branch_taken = 1'b0;
  logic       ext_stall = 1'b0;

  logic [6:0]  en1, en0;
  logic [3:0]  fwd1, fwd0, sv1, sv0;
  logic        wbw1, wbw0, busy1, busy0;
  logic [2:0]  wbd1, wbd0;
  logic [31:0] cnt1;
  logic [3:0]  cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_ADDR_W(3), .NUM_SRC(2), .FWD_EN(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .fetch_valid(fetch_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .pc_en(en1[6]), .ifid_en(en1[5]), .idex_en(en1[4]),
    .exmem_en(en1[3]), .memwb_en(en1[2]),
    .ifid_flush(en1[1]), .idex_bubble(en1[0]),
    .fwd_sel(fwd1), .stage_valid(sv1), .wb_reg_write(wbw1),
    .wb_dst_addr(wbd1), .busy(busy1), .retire_count(cnt1)
  );

  pipe_ctrl #(.REG_ADDR_W(3), .NUM_SRC(2), .FWD_EN(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .fetch_valid(fetch_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .pc_en(en0[6]), .ifid_en(en0[5]), .idex_en(en0[4]),
    .exmem_en(en0[3]), .memwb_en(en0[2]),
    .ifid_flush(en0[1]), .idex_bubble(en0[0]),
    .fwd_sel(fwd0), .stage_valid(sv0), .wb_reg_write(wbw0),
    .wb_dst_addr(wbd0), .busy(busy0), .retire_count(cnt0)
  );

  // Model: slot 0 = ID, 1 = EX, 2 = MEM, 3 = WB; index k = FWD_EN.
  bit          mv  [2][4];
  logic [2:0]  md  [2][4];
  bit          mrw [2][4];
  bit          mld [2][4];
  int          mmode [2];
  logic [31:0] mcnt [2];
  bit          e_lu;
  logic [3:0]  e_fwd;
  logic [6:0]  e_en;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mreset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        mv[k][j] = 0; md[k][j] = '0; mrw[k][j] = 0; mld[k][j] = 0;
      end
      mmode[k] = 0;
      mcnt[k]  = '0;
    end
  endfunction

  function automatic void eval(input int k);
    bit p [4];
    logic [2:0] a;
    e_lu = 0; e_fwd = '0; e_en = '0;
    for (int s = 0; s < 2; s++) begin
      a = id_src_addr[3*s +: 3];
      for (int j = 1; j < 4; j++)
        p[j] = mv[k][0] && id_src_used[s] && mv[k][j] && mrw[k][j] && (md[k][j] == a);
      if (p[1] && mld[k][1]) e_lu = 1;
      if (k == 0) begin
        if (p[1] || p[2] || p[3]) e_lu = 1;
      end else begin
        e_fwd[2*s +: 2] = (p[1] && !mld[k][1]) ? 2'b01 : (p[2] ? 2'b10 : 2'b00);
      end
    end
    if (mmode[k] != 0 && !ext_stall)
      e_en = branch_taken ? 7'b1111111 : (e_lu ? 7'b0011101 : 7'b1111100);
  endfunction

  function automatic void step(input int k);
    int old;
    eval(k);
    if (ext_stall) return;
    old = mmode[k];
    if (mv[k][3]) mcnt[k] = mcnt[k] + 32'd1;
    if (old == 0 && start && !halt) mmode[k] = 1;
    if (old == 1 && halt) mmode[k] = 2;
    if (old == 2 && !(mv[k][0] || mv[k][1] || mv[k][2] || mv[k][3])) mmode[k] = 0;
    if (old != 0) begin
      for (int j = 3; j >= 2; j--) begin
        mv[k][j] = mv[k][j-1]; md[k][j] = md[k][j-1];
        mrw[k][j] = mrw[k][j-1]; mld[k][j] = mld[k][j-1];
      end
      mv[k][1]  = mv[k][0] && !e_lu && !branch_taken;
      md[k][1]  = id_dst_addr;
      mrw[k][1] = id_reg_write && mv[k][1];
      mld[k][1] = id_mem_read && mv[k][1];
      if (branch_taken) mv[k][0] = 0;
      else if (!e_lu) mv[k][0] = (old == 1) && fetch_valid && !halt;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mreset();
    else begin
      step(0);
      step(1);
    end
  end

  task automatic cmp_k(input int k, input logic [6:0] en, input logic [3:0] fwd,
                       input logic [3:0] sv, input logic wbw, input logic [2:0] wbd,
                       input logic bz, input logic [31:0] cnt);
    logic [31:0] mask;
    bit ewb;
    mask = (k == 0) ? 32'h0000_000f : 32'hffff_ffff;
    ewb  = mv[k][3] && mrw[k][3];
    eval(k);
    chk($sformatf("m%0d_en", k), 32'(en), 32'(e_en));
    chk($sformatf("m%0d_valid", k), 32'(sv),
        32'({mv[k][3], mv[k][2], mv[k][1], mv[k][0]}));
    if (mv[k][0]) chk($sformatf("m%0d_fwd", k), 32'(fwd), 32'(e_fwd));
    chk($sformatf("m%0d_wbw", k), 32'(wbw), 32'(ewb));
    if (ewb) chk($sformatf("m%0d_wbd", k), 32'(wbd), 32'(md[k][3]));
    chk($sformatf("m%0d_busy", k), 32'(bz), 32'(mmode[k] != 0));
    chk($sformatf("m%0d_cnt", k), cnt, mcnt[k] & mask);
  endtask

  always @(negedge clk) begin
    cmp_k(0, en0, fwd0, sv0, wbw0, wbd0, busy0, {28'd0, cnt0});
    cmp_k(1, en1, fwd1, sv1, wbw1, wbd1, busy1, cnt1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic ins(input logic [2:0] d, input logic rw, input logic ld,
                     input logic [2:0] s0, input logic [2:0] s1,
                     input logic [1:0] u);
    id_dst_addr  = d;
    id_reg_write = rw;
    id_mem_read  = ld;
    id_src_addr  = {s1, s0};
    id_src_used  = u;
  endtask

  initial begin
    // Reset values, then async reset with a full pipe.
    cyc(); cyc();
    at_neg();
    chk("rst_en", 32'(en1), 32'd0);
    chk("rst_fwd", 32'(fwd1), 32'd0);
    chk("rst_valid", 32'(sv1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_cnt", cnt1, 32'd0);
    chk("rst_wbw", 32'(wbw1), 32'd0);
    cyc();
    rst = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; fetch_valid = 1'b1;
    ins(3'd7, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    repeat (4) cyc();
    at_neg();
    chk("t1_full", 32'(sv1), 32'hf);
    cyc();
    at_neg();
    chk("t1_cnt1", cnt1, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_valid", 32'(sv1), 32'd0);
    chk("t1_busy", 32'(busy1), 32'd0);
    chk("t1_cnt", cnt1, 32'd0);
    chk("t1_en", 32'(en1), 32'd0);
    cyc();
    rst = 1'b0; fetch_valid = 1'b0;
    ins(3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);

    // Forwarding, load-use, branch, then drain with ext_stall.
    start = 1'b1;
    cyc();
    start = 1'b0; fetch_valid = 1'b1;
    cyc();
    ins(3'd1, 1'b1, 1'b0, 3'd2, 3'd3, 2'b11);
    at_neg();
    chk("t2_fwd_a", 32'(fwd1), 32'd0);
    cyc();
    ins(3'd4, 1'b1, 1'b0, 3'd1, 3'd1, 2'b11);
    at_neg();
    chk("t2_fwd_b", 32'(fwd1), 32'(4'b0101));
    chk("t2_en", 32'(en1), 32'(7'b1111100));
    cyc();
    ins(3'd1, 1'b1, 1'b1, 3'd5, 3'd0, 2'b01);
    cyc();
    ins(3'd6, 1'b1, 1'b0, 3'd1, 3'd0, 2'b01);
    at_neg();
    chk("t3_stall_en", 32'(en1), 32'(7'b0011101));
    cyc();
    at_neg();
    chk("t3_fwd", 32'(fwd1), 32'(4'b0010));
    chk("t3_en", 32'(en1), 32'(7'b1111100));
    chk("t3_valid", 32'(sv1), 32'(4'b1101));
    cyc();
    ins(3'd2, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    branch_taken = 1'b1;
    at_neg();
    chk("t4_en", 32'(en1), 32'(7'b1111111));
    cyc();
    branch_taken = 1'b0;
    ins(3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'b00);
    at_neg();
    chk("t4_valid_h", 32'(sv1), 32'(4'b0100));
    cyc();
    ins(3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 2'b00);
    at_neg();
    chk("t4_valid_i", 32'(sv1), 32'(4'b1001));
    cyc();
    at_neg();
    chk("t4_wb_j", 32'(sv1[3]), 32'd0);
    cyc();
    at_neg();
    chk("t4_wb_k", 32'(sv1[3]), 32'd0);
    chk("t4_cnt", cnt1, 32'd4);
    cyc();
    halt = 1'b1;
    at_neg();
    chk("t6_full", 32'(sv1), 32'hf);
    cyc();
    halt = 1'b0; fetch_valid = 1'b0; ext_stall = 1'b1;
    at_neg();
    chk("t6_stall_en", 32'(en1), 32'd0);
    chk("t6_stall_cnt", cnt1, 32'd5);
    cyc(); cyc();
    at_neg();
    chk("t6_hold_valid", 32'(sv1), 32'(4'b1110));
    chk("t6_hold_cnt", cnt1, 32'd5);
    cyc();
    ext_stall = 1'b0;
    repeat (3) cyc();
    at_neg();
    chk("t6_empty", 32'(sv1), 32'd0);
    chk("t6_drain_busy", 32'(busy1), 32'd1);
    chk("t6_cnt", cnt1, 32'd8);
    cyc();
    at_neg();
    chk("t6_idle", 32'(busy1), 32'd0);
    chk("t6_idle_en", 32'(en1), 32'd0);

    // Stall-only instance: dependent pair stalls three cycles.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; fetch_valid = 1'b1;
    cyc();
    ins(3'd1, 1'b1, 1'b0, 3'd2, 3'd3, 2'b11);
    cyc();
    fetch_valid = 1'b0;
    ins(3'd4, 1'b1, 1'b0, 3'd1, 3'd5, 2'b01);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk($sformatf("t5_en%0d", i), 32'(en0),
          (i < 3) ? 32'(7'b0011101) : 32'(7'b1111100));
      chk($sformatf("t5_fwd%0d", i), 32'(fwd0), 32'd0);
      if (i == 0) chk("t5_fwd_on", 32'(fwd1), 32'(4'b0001));
      cyc();
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 599) == 0);
      start        = ($urandom_range(0, 7) == 0);
      halt         = ($urandom_range(0, 39) == 0);
      fetch_valid  = ($urandom_range(0, 3) != 0);
      id_src_addr  = 6'($urandom());
      id_src_used  = 2'($urandom());
      id_dst_addr  = 3'($urandom());
      id_reg_write = ($urandom_range(0, 3) != 0);
      id_mem_read  = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      ext_stall    = ($urandom_range(0, 9) == 0);
      cyc();
    end
    rst = 1'b0; start = 1'b0; halt = 1'b0; fetch_valid = 1'b0;
    branch_taken = 1'b0; ext_stall = 1'b0;
    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
